// File: rtl/mdio_phy_responder.sv
// MDIO (clause 22) PHY-side responder with a 32 x 16 register file.
// MDC is level-sampled in the clk domain; every rising MDC edge becomes a
// one-cycle bit_evt strobe that advances the frame FSM.
//
// Handshake: there is no valid/ready pair here. A controller bit is accepted
// only when bit_evt=1 and mdio_oe=1 in the same clk cycle; the responder owns
// the line exactly when mdio_in_oe=1, and mdio_in is forced to 0 otherwise.
// wr_stb is a one-cycle pulse qualifying wr_addr/wr_data; frame_err is a
// one-cycle pulse marking a discarded frame.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [15:0] ID_VALUE = 16'h0141
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_out,
    input  logic        mdio_oe,
    output logic        mdio_in,
    output logic        mdio_in_oe,
    output logic        wr_stb,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_TA    = 3'd2,
        S_WDATA = 3'd3,
        S_RDATA = 3'd4,
        S_SKIP  = 3'd5
    } state_t;

    localparam logic [15:0] PHY_ID1 = 16'h7809;

    state_t      state_q;
    logic        mdc_q;
    logic [4:0]  cnt_q;       // frame bits consumed so far, saturates at 31
    logic [12:0] hdr_q;       // header bits received before the 14th arrives
    logic [15:0] sh_q;        // read data out / write data in
    logic [4:0]  regad_q;
    logic        is_read_q;
    logic [15:0] regs_q [32];

    logic        bit_evt;
    logic [4:0]  cnt_d;
    logic [13:0] hdr_d;
    logic [1:0]  st_d;
    logic [1:0]  op_d;
    logic [4:0]  phyad_d;
    logic [4:0]  regad_d;
    logic [15:0] wdata_d;
    logic [15:0] rd_val_d;

    assign bit_evt     = mdc & ~mdc_q;
    assign cnt_d       = (cnt_q == 5'd31) ? 5'd31 : cnt_q + 5'd1;
    assign hdr_d       = {hdr_q, mdio_out};
    assign st_d        = hdr_d[13:12];
    assign op_d        = hdr_d[11:10];
    assign phyad_d     = hdr_d[9:5];
    assign regad_d     = hdr_d[4:0];
    assign wdata_d     = {sh_q[14:0], mdio_out};
    assign rd_val_d    = (regad_d == 5'd1) ? PHY_ID1 : regs_q[regad_d];
    assign dbg_state_o = state_q;

    // MDC edge detector
    always_ff @(posedge clk) begin
        if (!reset) begin
            mdc_q <= 1'b0;
        end else begin
            mdc_q <= mdc;
        end
    end

    // Frame FSM, register file and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            hdr_q      <= 13'd0;
            sh_q       <= 16'd0;
            regad_q    <= 5'd0;
            is_read_q  <= 1'b0;
            mdio_in    <= 1'b0;
            mdio_in_oe <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= 5'd0;
            wr_data    <= 16'd0;
            frame_err  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (i == 2) ? ID_VALUE : 16'h0000;
            end
        end else begin
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Preamble ones are ignored; the first 0 is ST[1]
                    if (bit_evt && mdio_oe && !mdio_out) begin
                        hdr_q   <= 13'd0;
                        cnt_q   <= 5'd1;
                        state_q <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (bit_evt) begin
                        if (!mdio_oe) begin
                            frame_err <= 1'b1;
                            cnt_q     <= 5'd0;
                            state_q   <= S_IDLE;
                        end else begin
                            hdr_q <= hdr_d[12:0];
                            cnt_q <= cnt_d;
                            if (cnt_q == 5'd13) begin
                                if (st_d != 2'b01 || (op_d != 2'b01 && op_d != 2'b10)) begin
                                    frame_err <= 1'b1;
                                    cnt_q     <= 5'd0;
                                    state_q   <= S_IDLE;
                                end else if (phyad_d != PHY_ADDR) begin
                                    state_q <= S_SKIP;
                                end else begin
                                    regad_q   <= regad_d;
                                    is_read_q <= (op_d == 2'b10);
                                    sh_q      <= (op_d == 2'b10) ? rd_val_d : 16'd0;
                                    state_q   <= S_TA;
                                end
                            end
                        end
                    end
                end
                S_TA: begin
                    if (bit_evt) begin
                        if (is_read_q) begin
                            // Controller releases the line during TA, so mdio_oe is not checked
                            cnt_q <= cnt_d;
                            if (cnt_q == 5'd14) begin
                                mdio_in_oe <= 1'b1;
                                mdio_in    <= 1'b0;
                            end else begin
                                mdio_in <= sh_q[15];
                                sh_q    <= {sh_q[14:0], 1'b0};
                                state_q <= S_RDATA;
                            end
                        end else if (!mdio_oe) begin
                            frame_err <= 1'b1;
                            cnt_q     <= 5'd0;
                            state_q   <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_d;
                            if (cnt_q == 5'd15) begin
                                state_q <= S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (bit_evt) begin
                        if (cnt_q == 5'd31) begin
                            // DATA[0] has been sampled by the controller; release the line
                            mdio_in_oe <= 1'b0;
                            mdio_in    <= 1'b0;
                            cnt_q      <= 5'd0;
                            state_q    <= S_IDLE;
                        end else begin
                            mdio_in <= sh_q[15];
                            sh_q    <= {sh_q[14:0], 1'b0};
                            cnt_q   <= cnt_d;
                        end
                    end
                end
                S_WDATA: begin
                    if (bit_evt) begin
                        if (!mdio_oe) begin
                            frame_err <= 1'b1;
                            cnt_q     <= 5'd0;
                            state_q   <= S_IDLE;
                        end else begin
                            sh_q  <= wdata_d;
                            cnt_q <= cnt_d;
                            if (cnt_q == 5'd31) begin
                                // Registers 1 and 2 are read-only but the strobe still fires
                                if (regad_q != 5'd1 && regad_q != 5'd2) begin
                                    regs_q[regad_q] <= wdata_d;
                                end
                                wr_stb  <= 1'b1;
                                wr_addr <= regad_q;
                                wr_data <= wdata_d;
                                cnt_q   <= 5'd0;
                                state_q <= S_IDLE;
                            end
                        end
                    end
                end
                S_SKIP: begin
                    // Frame for another PHY: count it out without touching the line
                    if (bit_evt) begin
                        if (cnt_q == 5'd31) begin
                            cnt_q   <= 5'd0;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: begin
                    cnt_q   <= 5'd0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: drives MDIO frames as a controller would,
// keeps a reference register model, and scores writes, errors and read data.
module tb_mdio_phy_responder;

    localparam logic [4:0]  PHY_ADDR = 5'd1;
    localparam logic [15:0] ID_VALUE = 16'h0141;

    logic        clk;
    logic        reset;
    logic        mdc;
    logic        mdio_out;
    logic        mdio_oe;
    logic        mdio_in;
    logic        mdio_in_oe;
    logic        wr_stb;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;
    logic [2:0]  dbg_state_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_exp  = 0;
    logic        skip_watch = 1'b0;
    logic [20:0] exp_q [$];     // expected writes {addr, data}
    logic [15:0] rd_q  [$];     // expected read data
    logic [15:0] model_regs [32];

    mdio_phy_responder #(
        .PHY_ADDR (PHY_ADDR),
        .ID_VALUE (ID_VALUE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mdc         (mdc),
        .mdio_out    (mdio_out),
        .mdio_oe     (mdio_oe),
        .mdio_in     (mdio_in),
        .mdio_in_oe  (mdio_in_oe),
        .wr_stb      (wr_stb),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_err   (frame_err),
        .dbg_state_o (dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = (i == 2) ? ID_VALUE : 16'h0000;
    endtask

    // driver tasks: each starts and ends at a clk falling edge with mdc low
    task automatic send_bit(input logic b, input logic oe);
        mdio_out = b;
        mdio_oe  = oe;
        repeat (2) @(negedge clk);
        mdc = 1'b1;
        repeat (2) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, 1'b1);
    endtask

    task automatic write_frame(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
        logic [31:0] f;
        f = {2'b01, 2'b01, phy, ra, 2'b10, d};
        if (phy == PHY_ADDR) begin
            exp_q.push_back({ra, d});
            if (ra != 5'd1 && ra != 5'd2) model_regs[ra] = d;
        end
        for (int i = 31; i >= 0; i--) send_bit(f[i], 1'b1);
    endtask

    // Write frame that loses mdio_oe on data bit drop_bit
    task automatic write_abort(input logic [4:0] ra, input logic [15:0] d, input int drop_bit);
        logic [31:0] f;
        logic        stop;
        f    = {2'b01, 2'b01, PHY_ADDR, ra, 2'b10, d};
        stop = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!stop) begin
                if (31 - i == 16 + drop_bit) begin
                    err_exp++;
                    send_bit(f[i], 1'b0);
                    stop = 1'b1;
                end else begin
                    send_bit(f[i], 1'b1);
                end
            end
        end
    endtask

    task automatic bad_header(input logic [1:0] st, input logic [1:0] op);
        logic [13:0] h;
        h = {st, op, PHY_ADDR, 5'd4};
        err_exp++;
        for (int i = 13; i >= 0; i--) send_bit(h[i], 1'b1);
    endtask

    // Frame for another PHY; the controller drops mdio_oe over TA to show it is ignored
    task automatic skip_frame(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
        logic [31:0] f;
        f = {2'b01, 2'b01, phy, ra, 2'b10, d};
        skip_watch = 1'b1;
        for (int i = 31; i >= 1; i--) send_bit(f[i], (31 - i < 14 || 31 - i >= 16));
        check("skip_state", dbg_state_o, 3'd5);
        send_bit(f[0], 1'b1);
        check("skip_idle", dbg_state_o, 3'd0);
        skip_watch = 1'b0;
    endtask

    // Read frame; rst_at >= 0 pulses reset during that data bit instead of finishing
    task automatic read_frame(input logic [4:0] ra, input int rst_at);
        logic [13:0] h;
        logic [15:0] got;
        logic [15:0] e;
        logic        aborted;
        h       = {2'b01, 2'b10, PHY_ADDR, ra};
        got     = 16'h0;
        aborted = 1'b0;
        rd_q.push_back((ra == 5'd1) ? 16'h7809 : model_regs[ra]);
        for (int i = 13; i >= 0; i--) send_bit(h[i], 1'b1);
        mdio_out = 1'b0;
        mdio_oe  = 1'b0;
        repeat (2) @(negedge clk);
        check("ta_pre_oe", mdio_in_oe, 1'b0);
        mdc = 1'b1;
        repeat (2) @(negedge clk);
        mdc = 1'b0;
        repeat (2) @(negedge clk);
        check("ta1_oe", mdio_in_oe, 1'b1);
        check("ta1_in", mdio_in, 1'b0);
        mdc = 1'b1;
        repeat (2) @(negedge clk);
        mdc = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!aborted) begin
                repeat (2) @(negedge clk);
                if (rst_at == 15 - i) begin
                    reset = 1'b0;
                    @(negedge clk);
                    check("rst_oe", mdio_in_oe, 1'b0);
                    check("rst_in", mdio_in, 1'b0);
                    reset = 1'b1;
                    model_reset();
                    void'(rd_q.pop_front());
                    aborted = 1'b1;
                end else begin
                    check("rd_oe", mdio_in_oe, 1'b1);
                    got[i] = mdio_in;
                    mdc = 1'b1;
                    repeat (2) @(negedge clk);
                    mdc = 1'b0;
                end
            end
        end
        if (!aborted) begin
            check("rd_release_oe", mdio_in_oe, 1'b0);
            e = rd_q.pop_front();
            check($sformatf("rd_reg%0d", ra), got, e);
        end
    endtask

    task automatic settle();
        check("err_missing", err_exp, 0);
        check("wr_missing", exp_q.size(), 0);
    endtask

    // scoreboard monitor: consumes DUT strobes and checks line ownership
    always @(negedge clk) begin
        logic [20:0] e;
        if (reset) begin
            if (wr_stb) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", wr_stb, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", wr_addr, e[20:16]);
                    check("wr_data", wr_data, e[15:0]);
                end
            end
            if (frame_err) begin
                if (err_exp == 0) check("err_unexpected", frame_err, 1'b0);
                else err_exp--;
            end
            if (!mdio_in_oe) check("in_when_released", mdio_in, 1'b0);
            if (skip_watch) check("skip_oe", mdio_in_oe, 1'b0);
        end
    end

    initial begin
        logic [4:0]  ra;
        logic [15:0] d;
        reset    = 1'b0;
        mdc      = 1'b0;
        mdio_out = 1'b1;
        mdio_oe  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_mdio_in", mdio_in, 1'b0);
        check("rst_mdio_in_oe", mdio_in_oe, 1'b0);
        check("rst_wr_stb", wr_stb, 1'b0);
        check("rst_wr_addr", wr_addr, 5'd0);
        check("rst_wr_data", wr_data, 16'd0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_state", dbg_state_o, 3'd0);
        reset = 1'b1;
        @(negedge clk);

        // ID register and constant register after reset
        preamble(32);
        read_frame(5'd2, -1);
        preamble(4);
        read_frame(5'd1, -1);

        // basic write then read back
        preamble(32);
        write_frame(PHY_ADDR, 5'd5, 16'hABCD);
        preamble(2);
        read_frame(5'd5, -1);
        settle();

        // read-only registers still strobe but keep their value
        preamble(2);
        write_frame(PHY_ADDR, 5'd1, 16'h1111);
        write_frame(PHY_ADDR, 5'd2, 16'h2222);
        read_frame(5'd2, -1);
        read_frame(5'd1, -1);
        settle();

        // frame addressed to another PHY
        preamble(2);
        skip_frame(5'd3, 5'd5, 16'h5555);
        read_frame(5'd5, -1);
        settle();

        // mdio_oe dropped mid-data
        preamble(2);
        write_frame(PHY_ADDR, 5'd7, 16'h1234);
        preamble(1);
        write_abort(5'd7, 16'hFFFF, 8);
        preamble(3);
        read_frame(5'd7, -1);
        settle();

        // malformed headers, each followed at once by a valid write
        bad_header(2'b00, 2'b01);
        write_frame(PHY_ADDR, 5'd9, 16'h0F0F);
        bad_header(2'b01, 2'b11);
        write_frame(PHY_ADDR, 5'd10, 16'hA5A5);
        bad_header(2'b01, 2'b00);
        write_frame(PHY_ADDR, 5'd11, 16'h8001);
        read_frame(5'd9, -1);
        read_frame(5'd10, -1);
        read_frame(5'd11, -1);
        settle();

        // random back-to-back traffic
        for (int k = 0; k < 8; k++) begin
            ra = 5'($urandom_range(0, 31));
            d  = 16'($urandom_range(0, 65535));
            preamble($urandom_range(0, 3));
            write_frame(PHY_ADDR, ra, d);
            preamble($urandom_range(0, 2));
            read_frame(5'($urandom_range(0, 31)), -1);
            read_frame(ra, -1);
        end
        settle();

        // reset in the middle of read data
        preamble(2);
        read_frame(5'd2, 5);
        mdio_oe = 1'b0;
        repeat (4) @(negedge clk);
        preamble(32);
        read_frame(5'd2, -1);
        read_frame(5'd5, -1);
        settle();

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
